peak_finder: RTL and testbench

Streaming peak detector placed after the squared-magnitude estimator in the FFT/range-processing chain. Over each frame (delimited by tlast) it tracks the largest tdata sample that exceeds a programmable threshold. It outputs that sample's index, value and user tag, plus the count of above-threshold samples. The result is final on the output beat flagged peak_tlast.

---
 rtl/peak_finder_pkg.sv | 16 +
 rtl/peak_finder.sv | 153 +++++++++++++++
 tb/tb_peak_finder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/peak_finder_pkg.sv
// peak_finder_pkg: shared widths and constants for the peak detector.
//   DEF_DATA_LEN  - default sample magnitude / threshold width
//   DEF_INDEX_LEN - default sample index width
//   DEF_TUSER_LEN - default side-band tag width
//   DEF_COUNT_LEN - default above-threshold counter width
//   DEF_COUNT_MAX - saturation value of the counter at the default width
package peak_finder_pkg;

  localparam int DEF_DATA_LEN  = 64;
  localparam int DEF_INDEX_LEN = 32;
  localparam int DEF_TUSER_LEN = 32;
  localparam int DEF_COUNT_LEN = 32;

  localparam logic [DEF_COUNT_LEN-1:0] DEF_COUNT_MAX = '1;

endpackage

// File: rtl/peak_finder.sv
// peak_finder: streaming per-frame maximum detector with 1-cycle latency.
// Tracks the largest above-threshold sample of each tlast-delimited frame
// and reports its value, index and tag together with a saturating count.
//   clk         - rising-edge clock
//   areset      - asynchronous active-high reset
//   tdata       - unsigned sample magnitude
//   tvalid      - sample qualifier (no backpressure)
//   tlast       - last sample of frame, qualified by tvalid
//   tuser       - side-band tag of the sample
//   index       - sample index within the frame
//   threshold   - detection threshold, sampled on every valid beat
//   peak_index  - index of the frame maximum so far
//   peak_tdata  - value of the frame maximum so far
//   peak_tvalid - one pulse per consumed input beat
//   peak_tlast  - marks the final result of a frame
//   peak_tuser  - tag of the frame maximum so far
//   num_peaks   - above-threshold samples in the frame so far
module peak_finder
  import peak_finder_pkg::*;
#(
  parameter int DATA_LEN  = DEF_DATA_LEN,
  parameter int INDEX_LEN = DEF_INDEX_LEN,
  parameter int TUSER_LEN = DEF_TUSER_LEN,
  parameter int COUNT_LEN = DEF_COUNT_LEN
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [DATA_LEN-1:0]  tdata,
  input  logic                 tvalid,
  input  logic                 tlast,
  input  logic [TUSER_LEN-1:0] tuser,
  input  logic [INDEX_LEN-1:0] index,
  input  logic [DATA_LEN-1:0]  threshold,
  output logic [INDEX_LEN-1:0] peak_index,
  output logic [DATA_LEN-1:0]  peak_tdata,
  output logic                 peak_tvalid,
  output logic                 peak_tlast,
  output logic [TUSER_LEN-1:0] peak_tuser,
  output logic [COUNT_LEN-1:0] num_peaks
);

  localparam logic [COUNT_LEN-1:0] CNT_SAT = '1;

  // frame accumulators
  logic                 first_q, first_d;
  logic [DATA_LEN-1:0]  max_q, max_d;
  logic [INDEX_LEN-1:0] idx_q, idx_d;
  logic [TUSER_LEN-1:0] user_q, user_d;
  logic [COUNT_LEN-1:0] cnt_q, cnt_d;

  // output register stage
  logic                 pvalid_q, pvalid_d;
  logic                 plast_q, plast_d;
  logic [DATA_LEN-1:0]  pdata_q, pdata_d;
  logic [INDEX_LEN-1:0] pindex_q, pindex_d;
  logic [TUSER_LEN-1:0] puser_q, puser_d;
  logic [COUNT_LEN-1:0] pcnt_q, pcnt_d;

  // frame-so-far view: a fresh frame behaves as all zeros
  logic [DATA_LEN-1:0]  cur_max;
  logic [INDEX_LEN-1:0] cur_idx;
  logic [TUSER_LEN-1:0] cur_user;
  logic [COUNT_LEN-1:0] cur_cnt;
  logic                 qual, upd;
  logic [DATA_LEN-1:0]  new_max;
  logic [INDEX_LEN-1:0] new_idx;
  logic [TUSER_LEN-1:0] new_user;
  logic [COUNT_LEN-1:0] new_cnt;

  always_comb begin
    cur_max  = first_q ? '0 : max_q;
    cur_idx  = first_q ? '0 : idx_q;
    cur_user = first_q ? '0 : user_q;
    cur_cnt  = first_q ? '0 : cnt_q;

    qual = tvalid && (tdata > threshold);
    // strict compare keeps the earliest of equal maxima
    upd  = qual && (tdata > cur_max);

    new_max  = upd ? tdata : cur_max;
    new_idx  = upd ? index : cur_idx;
    new_user = upd ? tuser : cur_user;
    new_cnt  = (qual && (cur_cnt != CNT_SAT)) ? cur_cnt + 1'b1 : cur_cnt;

    first_d  = first_q;
    max_d    = max_q;
    idx_d    = idx_q;
    user_d   = user_q;
    cnt_d    = cnt_q;
    pdata_d  = pdata_q;
    pindex_d = pindex_q;
    puser_d  = puser_q;
    pcnt_d   = pcnt_q;
    pvalid_d = tvalid;
    plast_d  = tvalid && tlast;

    if (tvalid) begin
      pdata_d  = new_max;
      pindex_d = new_idx;
      puser_d  = new_user;
      pcnt_d   = new_cnt;
      if (tlast) begin
        first_d = 1'b1;
        max_d   = '0;
        idx_d   = '0;
        user_d  = '0;
        cnt_d   = '0;
      end else begin
        first_d = 1'b0;
        max_d   = new_max;
        idx_d   = new_idx;
        user_d  = new_user;
        cnt_d   = new_cnt;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      first_q  <= 1'b1;
      max_q    <= '0;
      idx_q    <= '0;
      user_q   <= '0;
      cnt_q    <= '0;
      pvalid_q <= 1'b0;
      plast_q  <= 1'b0;
      pdata_q  <= '0;
      pindex_q <= '0;
      puser_q  <= '0;
      pcnt_q   <= '0;
    end else begin
      first_q  <= first_d;
      max_q    <= max_d;
      idx_q    <= idx_d;
      user_q   <= user_d;
      cnt_q    <= cnt_d;
      pvalid_q <= pvalid_d;
      plast_q  <= plast_d;
      pdata_q  <= pdata_d;
      pindex_q <= pindex_d;
      puser_q  <= puser_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign peak_tvalid = pvalid_q;
  assign peak_tlast  = plast_q;
  assign peak_tdata  = pdata_q;
  assign peak_index  = pindex_q;
  assign peak_tuser  = puser_q;
  assign num_peaks   = pcnt_q;

endmodule

// File: tb/tb_peak_finder.sv
module tb_peak_finder;

  localparam int CL = 6;
  localparam int SAT = (1 << CL) - 1;

  logic          clk = 1'b0;
  logic          areset;
  logic [63:0]   tdata, threshold;
  logic          tvalid, tlast;
  logic [31:0]   tuser, index;
  logic [31:0]   peak_index, peak_tuser;
  logic [63:0]   peak_tdata;
  logic          peak_tvalid, peak_tlast;
  logic [CL-1:0] num_peaks;

  peak_finder #(.COUNT_LEN(CL)) dut (
    .clk(clk), .areset(areset), .tdata(tdata), .tvalid(tvalid), .tlast(tlast),
    .tuser(tuser), .index(index), .threshold(threshold),
    .peak_index(peak_index), .peak_tdata(peak_tdata), .peak_tvalid(peak_tvalid),
    .peak_tlast(peak_tlast), .peak_tuser(peak_tuser), .num_peaks(num_peaks)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned cyc;
    logic            last;
    logic [63:0]     d;
    logic [31:0]     i;
    logic [31:0]     u;
    logic [CL-1:0]   n;
  } exp_t;

  exp_t            expq[$];
  exp_t            hold;
  logic [63:0]     fd[$];
  logic [31:0]     fi[$];
  logic [31:0]     fu[$];
  logic [63:0]     thr;
  longint unsigned cyc = 0;
  int              checks = 0;
  int              passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input logic ok, input string name, input logic [135:0] act,
                     input logic [135:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference: the result is the first-occurring largest element among the
  // qualifying samples of the frame so far; count is their number, capped.
  function automatic exp_t frame_result();
    exp_t r;
    r.d = '0; r.i = '0; r.u = '0;
    foreach (fd[k]) begin
      if (fd[k] > r.d) begin
        r.d = fd[k]; r.i = fi[k]; r.u = fu[k];
      end
    end
    r.n = (fd.size() > SAT) ? CL'(SAT) : CL'(fd.size());
    r.cyc = 0; r.last = 1'b0;
    return r;
  endfunction

  task automatic clear_frame();
    fd.delete(); fi.delete(); fu.delete();
  endtask

  task automatic beat(input logic [63:0] d, input logic [31:0] i, input logic [31:0] u,
                      input logic l);
    exp_t e;
    tvalid = 1'b1; tdata = d; index = i; tuser = u; tlast = l; threshold = thr;
    if (d > thr) begin
      fd.push_back(d); fi.push_back(i); fu.push_back(u);
    end
    e = frame_result();
    e.cyc = cyc + 1;
    e.last = l;
    expq.push_back(e);
    if (l) clear_frame();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tvalid = 1'b0;
      tlast = 1'($urandom_range(0, 1));
      tdata = 64'($urandom_range(0, 1000));
      threshold = 64'($urandom_range(0, 1000));
      @(posedge clk); #1;
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!areset) begin
      if (peak_tvalid) begin
        chk(expq.size() != 0, "unexpected_beat", 136'(expq.size()), 136'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk(cyc == e.cyc, "latency", 136'(cyc), 136'(e.cyc));
          chk(peak_tlast == e.last, "peak_tlast", 136'(peak_tlast), 136'(e.last));
          chk(peak_tdata == e.d, "peak_tdata", 136'(peak_tdata), 136'(e.d));
          chk({peak_index, peak_tuser, num_peaks} == {e.i, e.u, e.n}, "idx_user_cnt",
              136'({peak_index, peak_tuser, num_peaks}), 136'({e.i, e.u, e.n}));
          hold = e;
        end
      end else begin
        chk(peak_tlast == 1'b0, "gap_tlast", 136'(peak_tlast), 136'd0);
        chk({peak_tdata, peak_index, peak_tuser, num_peaks} == {hold.d, hold.i, hold.u, hold.n},
            "gap_hold", 136'({peak_tdata, peak_index, peak_tuser, num_peaks}),
            136'({hold.d, hold.i, hold.u, hold.n}));
      end
    end
  end

  logic [63:0] basic_d [8];
  logic [63:0] r_d;

  initial begin
    basic_d = '{64'd1, 64'd5, 64'd300, 64'd20, 64'd400, 64'd400, 64'd10, 64'd0};
    hold = '{cyc: 0, last: 1'b0, d: '0, i: '0, u: '0, n: '0};
    areset = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tuser = '0; index = '0;
    threshold = '0; thr = 64'd255;
    #23;
    chk({peak_tvalid, peak_tlast, peak_tdata, peak_index, peak_tuser, num_peaks} == '0,
        "reset_outputs", 136'({peak_tdata, num_peaks}), 136'd0);
    @(negedge clk); areset = 1'b0;
    @(posedge clk); #1;

    // basic frame
    for (int k = 0; k < 8; k++) beat(basic_d[k], 32'(k), 32'(k + 16), k == 7);
    idle(2);
    chk(peak_tdata == 64'd400, "basic_tdata", 136'(peak_tdata), 136'd400);
    chk(peak_index == 32'd4, "basic_index", 136'(peak_index), 136'd4);
    chk(peak_tuser == 32'd20, "basic_tuser", 136'(peak_tuser), 136'd20);
    chk(num_peaks == CL'(3), "basic_count", 136'(num_peaks), 136'd3);

    // nothing over threshold
    for (int k = 0; k < 8; k++) beat(64'd255, 32'(k), 32'(k + 16), k == 7);
    idle(1);
    chk({peak_tdata, peak_index, num_peaks} == '0, "none_over",
        136'({peak_tdata, peak_index, num_peaks}), 136'd0);

    // back-to-back frames
    for (int k = 0; k < 8; k++) beat(basic_d[k], 32'(k), 32'(k + 16), k == 7);
    beat(64'd260, 32'd0, 32'd7, 1'b0);
    beat(64'd1, 32'd1, 32'd8, 1'b1);
    idle(1);
    chk({peak_tdata, peak_index, num_peaks} == {64'd260, 32'd0, CL'(1)}, "frame_b",
        136'({peak_tdata, peak_index, num_peaks}), 136'({64'd260, 32'd0, CL'(1)}));

    // gaps between beats, with stray tlast while idle
    for (int k = 0; k < 8; k++) begin
      beat(basic_d[k], 32'(k), 32'(k + 16), k == 7);
      idle(int'($urandom_range(0, 3)));
    end

    // single-beat frames and a tie
    beat(64'd256, 32'd3, 32'd9, 1'b1);
    beat(64'd255, 32'd3, 32'd9, 1'b1);
    beat(64'd300, 32'd0, 32'd1, 1'b0);
    beat(64'd300, 32'd1, 32'd2, 1'b0);
    beat(64'd299, 32'd2, 32'd3, 1'b1);
    idle(2);
    chk(peak_index == 32'd0, "tie_earliest", 136'(peak_index), 136'd0);

    // reset mid-frame
    beat(64'd300, 32'd0, 32'd0, 1'b0);
    beat(64'd500, 32'd1, 32'd1, 1'b0);
    idle(2);
    #2 areset = 1'b1;
    #1;
    chk({peak_tvalid, peak_tlast, peak_tdata, peak_index, peak_tuser, num_peaks} == '0,
        "async_reset", 136'({peak_tdata, peak_index, num_peaks}), 136'd0);
    clear_frame();
    hold = '{cyc: 0, last: 1'b0, d: '0, i: '0, u: '0, n: '0};
    tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #3 areset = 1'b0;
    @(posedge clk); #1;
    beat(64'd270, 32'd0, 32'd5, 1'b1);
    idle(1);
    chk({peak_tdata, num_peaks} == {64'd270, CL'(1)}, "after_reset",
        136'({peak_tdata, num_peaks}), 136'({64'd270, CL'(1)}));

    // ramp frame
    for (int k = 0; k <= 240; k++) begin
      r_d = (k <= 207) ? 64'(162 + k) : 64'(369 - (k - 207) * 3);
      beat(r_d, 32'(k), 32'(k), k == 240);
    end
    idle(1);
    chk({peak_index, peak_tdata} == {32'd207, 64'd369}, "ramp",
        136'({peak_index, peak_tdata}), 136'({32'd207, 64'd369}));

    // counter saturation
    thr = 64'd0;
    for (int k = 0; k < 80; k++) beat(64'($urandom_range(1, 1000)), 32'(k), 32'(k), k == 79);
    idle(1);
    chk(num_peaks == CL'(SAT), "count_saturate", 136'(num_peaks), 136'(SAT));

    // random frames with mid-frame threshold changes and gaps
    for (int f = 0; f < 12; f++) begin
      int len;
      len = int'($urandom_range(1, 20));
      thr = 64'($urandom_range(0, 500));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 5) == 0) thr = 64'($urandom_range(0, 500));
        beat(64'($urandom_range(0, 40)) * 15, 32'(k), $urandom, k == len - 1);
        idle(int'($urandom_range(0, 2)));
      end
    end

    idle(3);
    chk(expq.size() == 0, "drain", 136'(expq.size()), 136'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
